mem_lsu: RTL

//  MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and

---
 rtl/mem_lsu.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-RAM bus transaction per load/store over a
// req/gnt + rvalid handshake, with lane steering, load extension, writeback and
// pipeline stall generation.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  mem_opcode_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_rs2_reg_data_i,
  input  logic        mem_rd_wr_en_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [31:0] mem_rd_reg_data_i,
  input  logic        mem_flush_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_rd_wr_en_o,
  output logic [4:0]  mem_rd_addr_o,
  output logic [31:0] mem_rd_reg_data_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [29:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [4:0]         rd_q;
  logic               en_q;
  logic [31:0]        ld_data_q;
  logic               discard_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               is_load;
  logic               is_store;
  logic               legal;
  logic               misaligned;
  logic               start_c;
  logic               misalign_c;
  logic               timeout_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;

  // Select the addressed lane of a load word and sign/zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Decode the EX/MEM instruction: legality, alignment, byte enables and store data.
  always_comb begin
    is_load  = (mem_opcode_i == OP_LOAD);
    is_store = (mem_opcode_i == OP_STORE);
    legal    = 1'b0;
    if (is_load)
      legal = mem_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      legal = mem_funct3_i inside {3'b000, 3'b001, 3'b010};
    case (mem_funct3_i[1:0])
      2'b01:   misaligned = mem_addr_i[0];
      2'b10:   misaligned = |mem_addr_i[1:0];
      default: misaligned = 1'b0;
    endcase
    be_c    = 4'hF;
    wdata_c = 32'd0;
    if (is_store) begin
      case (mem_funct3_i[1:0])
        2'b00: begin
          be_c    = 4'b0001 << mem_addr_i[1:0];
          wdata_c = {4{mem_rs2_reg_data_i[7:0]}};
        end
        2'b01: begin
          be_c    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{mem_rs2_reg_data_i[15:0]}};
        end
        default: begin
          be_c    = 4'hF;
          wdata_c = mem_rs2_reg_data_i;
        end
      endcase
    end
    start_c    = legal & ~misaligned & ~mem_flush_i;
    misalign_c = legal &  misaligned & ~mem_flush_i;
  end

  // Transfer is aborted once the REQ+RSP cycle budget is used up.
  assign timeout_c = ((state == S_REQ) || (state == S_RSP)) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Transfer FSM with latched request attributes and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= 30'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
      en_q      <= 1'b0;
      ld_data_q <= 32'd0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_c) begin
            addr_q    <= mem_addr_i[31:2];
            be_q      <= be_c;
            wdata_q   <= wdata_c;
            we_q      <= is_store;
            f3_q      <= mem_funct3_i;
            off_q     <= mem_addr_i[1:0];
            rd_q      <= mem_rd_addr_i;
            en_q      <= mem_rd_wr_en_i;
            ld_data_q <= 32'd0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (timeout_c) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (dbus_gnt_i) begin
            discard_q <= discard_q | mem_flush_i;
            cnt_q     <= cnt_q + CNT_W'(1);
            state     <= S_RSP;
          end else if (mem_flush_i) begin
            state <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RSP: begin
          if (timeout_c) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (dbus_rvalid_i) begin
            ld_data_q <= load_ext(f3_q, off_q, dbus_rdata_i);
            discard_q <= discard_q | mem_flush_i;
            state     <= S_DONE;
          end else begin
            discard_q <= discard_q | mem_flush_i;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = {addr_q, 2'b00};
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;

  // Handshake, stall, pulse and writeback outputs decoded from state and EX/MEM inputs.
  always_comb begin
    dbus_req_o        = (state == S_REQ) && !timeout_c;
    mem_bus_err_o     = timeout_c;
    mem_stall_o       = 1'b0;
    mem_misalign_o    = 1'b0;
    mem_rd_wr_en_o    = 1'b0;
    mem_rd_addr_o     = mem_rd_addr_i;
    mem_rd_reg_data_o = mem_rd_reg_data_i;
    case (state)
      S_IDLE: begin
        if (is_load || is_store) begin
          mem_stall_o    = start_c;
          mem_misalign_o = misalign_c;
        end else begin
          mem_rd_wr_en_o = mem_rd_wr_en_i & ~mem_flush_i;
        end
      end
      S_REQ, S_RSP: begin
        mem_stall_o       = 1'b1;
        mem_rd_addr_o     = rd_q;
        mem_rd_reg_data_o = ld_data_q;
      end
      default: begin
        mem_rd_addr_o     = rd_q;
        mem_rd_reg_data_o = ld_data_q;
        mem_rd_wr_en_o    = en_q & ~we_q & ~discard_q & ~err_q & ~mem_flush_i;
      end
    endcase
    if (rst) begin
      dbus_req_o        = 1'b0;
      mem_bus_err_o     = 1'b0;
      mem_stall_o       = 1'b0;
      mem_misalign_o    = 1'b0;
      mem_rd_wr_en_o    = 1'b0;
      mem_rd_addr_o     = 5'd0;
      mem_rd_reg_data_o = 32'd0;
    end
  end

endmodule
